// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator: registered adder tree over N_IN signed products,
// PASSES-beat accumulation, bias, optional ReLU and signed output saturation.
module conv_psum_accum #(
  parameter int N_IN   = 6,
  parameter int IN_W   = 32,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int PASSES = 3
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 bias_we,
  input  logic [ACC_W-1:0]     bias_in,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat
);
  localparam int L     = $clog2(N_IN);
  localparam int CNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASSES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Element count at a tree level; an odd leftover is carried forward.
  function automatic int lvl_n(input int lvl);
    int n;
    n = N_IN;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  bias_q, bias_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              accept;
  logic [ACC_W-1:0]  tree_sum;
  logic              tree_vld;
  logic [ACC_W-1:0]  grp_sum;
  logic signed [ACC_W-1:0] res;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~clr;

  // Level 0 registers the sign-extended beat; levels 1..L each add pairs.
  genvar gi, gj;
  for (gi = 0; gi <= L; gi++) begin : g_lvl
    localparam int NW = lvl_n(gi);
    logic [NW*ACC_W-1:0] src;
    logic [NW*ACC_W-1:0] data_d, data_q;
    logic                src_vld, vld_d, vld_q;

    if (gi == 0) begin : g_in
      for (gj = 0; gj < NW; gj++) begin : g_ext
        assign src[gj*ACC_W +: ACC_W] = ACC_W'($signed(in_data[gj*IN_W +: IN_W]));
      end
      assign src_vld = accept;
    end else begin : g_add
      localparam int NP = lvl_n(gi - 1);
      for (gj = 0; gj < NW; gj++) begin : g_pair
        if (2*gj + 1 < NP) begin : g_sum
          assign src[gj*ACC_W +: ACC_W] = g_lvl[gi-1].data_q[2*gj*ACC_W +: ACC_W]
                                        + g_lvl[gi-1].data_q[(2*gj+1)*ACC_W +: ACC_W];
        end else begin : g_pass
          assign src[gj*ACC_W +: ACC_W] = g_lvl[gi-1].data_q[2*gj*ACC_W +: ACC_W];
        end
      end
      assign src_vld = g_lvl[gi-1].vld_q;
    end

    always_comb begin
      data_d = stall ? data_q : src;
      vld_d  = clr ? 1'b0 : (stall ? vld_q : src_vld);
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end
  end

  assign tree_sum = g_lvl[L].data_q;
  assign tree_vld = g_lvl[L].vld_q;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    bias_d      = bias_we ? bias_in : bias_q;
    grp_sum     = acc_q + tree_sum;
    res         = grp_sum + bias_q;
    if (relu_en && res[ACC_W-1]) res = '0;

    if (clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (tree_vld && !stall) begin
        if (cnt_q != CNT_LAST) begin
          acc_d = grp_sum;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          if (res > SAT_MAX) begin
            out_data_d = SAT_MAX[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else if (res < SAT_MIN) begin
            out_data_d = SAT_MIN[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_data_d = res[OUT_W-1:0];
            out_sat_d  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule
